// File: rtl/counter_pkg.sv
// Shared constants and helpers for the modulo counter and its prescaler.
package counter_pkg;

    // Direction encoding on the Up input.
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Bits needed to hold a count of 0..n-1; never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts enabled cycles 0..PRESCALE-1 and pulses Step on the last
// one. Restart throws away any partial progress on the next edge.
module tick_gen
    import counter_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Enable,
    input  logic Restart,
    output logic Step
);

    localparam int unsigned     CW   = cnt_width(PRESCALE);
    localparam logic [CW-1:0]   LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Step decode and next prescaler value; Restart outranks a pending step.
    always_comb begin
        Step  = Enable & ~Restart & (cnt_q == LAST);
        cnt_d = cnt_q;
        if (Restart) begin
            cnt_d = '0;
        end else if (Step) begin
            cnt_d = '0;
        end else if (Enable) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Prescaler register, cleared asynchronously by Reset.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mod_counter.sv
// Up/down modulo counter with prescaled stepping, synchronous clear/load,
// a one-cycle wrap pulse and a sticky wrap flag.
module mod_counter
    import counter_pkg::*;
#(
    parameter int unsigned     WIDTH    = 8,
    parameter longint unsigned MODULUS  = 256,
    parameter int unsigned     PRESCALE = 1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Enable,
    input  logic             Up,
    input  logic             Clear,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadValue,
    output logic [WIDTH-1:0] CounterValue,
    output logic             Step,
    output logic             Wrap,
    output logic             WrapSticky,
    output logic             Terminal
);

    // Largest legal count; with MODULUS == 2**WIDTH this is all ones, so the
    // wrap compare below degenerates to natural binary overflow/underflow.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             sticky_q;
    logic             sticky_d;
    logic             tick;

    // Clear or Load restart the prescaler so the next step needs a full period.
    tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .Clock   (Clock),
        .Reset   (Reset),
        .Enable  (Enable),
        .Restart (Clear | Load),
        .Step    (tick)
    );

    // Next count and flags: Clear > Load > step > hold.
    always_comb begin
        count_d  = count_q;
        wrap_d   = 1'b0;
        sticky_d = sticky_q;
        if (Clear) begin
            count_d  = '0;
            sticky_d = 1'b0;
        end else if (Load) begin
            count_d = (LoadValue > MAX_VAL) ? MAX_VAL : LoadValue;
        end else if (tick) begin
            if (Up == DIR_UP) begin
                if (count_q == MAX_VAL) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (count_q == '0) begin
                    count_d = MAX_VAL;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
            sticky_d = sticky_q | wrap_d;
        end
    end

    // Count and flag registers, cleared asynchronously by Reset.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            count_q  <= '0;
            wrap_q   <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            wrap_q   <= wrap_d;
            sticky_q <= sticky_d;
        end
    end

    // Terminal looks at the end of the range in the current direction.
    always_comb begin
        Terminal = (Up == DIR_UP) ? (count_q == MAX_VAL) : (count_q == '0);
    end

    assign CounterValue = count_q;
    assign Step         = tick;
    assign Wrap         = wrap_q;
    assign WrapSticky   = sticky_q;

endmodule
